mmio_seg_display: RTL and testbench

- Memory-mapped, parametrised N-digit 7-segment display peripheral on the Hack data bus; replaces the fixed 4-digit display wired directly to RAM read data.
- Sits beside the data RAM and decodes its own address window from CPU addressM/writeM/outM. Read data is muxed into inM on `hit`.
- Adds registered digit storage, optional frame-synchronous (tear-free) update, per-digit blank and decimal-point masks, anti-ghosting blanking, and a frame tick.

---
 rtl/mmio_seg_display_pkg.sv | 34 +++
 rtl/mmio_seg_display_if.sv | 13 +
 rtl/mmio_seg_display_hex_to_seg.sv | 15 +
 rtl/mmio_seg_display.sv | 196 +++++++++++++++++++
 tb/tb_mmio_seg_display.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_seg_display_pkg.sv
// Shared constants for the memory-mapped 7-segment display peripheral:
// register offsets, CTRL/STATUS bit positions and the hex glyph table.
package seg_display_pkg;

    // DATA words start at the base of the window.
    localparam int DATA_OFF = 0;

    // CTRL, BLANK and STATUS follow the DATA words.
    // These offsets are counted from BASE + number of DATA words.
    localparam int CTRL_REL   = 0;
    localparam int BLANK_REL  = 1;
    localparam int STATUS_REL = 2;

    // CTRL register fields.
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SYNC_BIT = 1;
    localparam int CTRL_DP_LSB   = 8;

    // STATUS register fields.
    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_IDX_LSB  = 8;

    // Active-high glyphs, bit order g..a (bit 6 = g, bit 0 = a).
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Number of 16-bit DATA words needed to hold all digit nibbles.
    function automatic int num_words(input int digits);
        return (digits + 3) / 4;
    endfunction

endpackage

// File: rtl/mmio_seg_display_if.sv
// CPU-side data bus for the display peripheral.
// The Hack CPU drives addressM/writeM/outM.
// The peripheral returns read data and a window-hit flag.
interface mmio_seg_display_if;
    logic [15:0] address;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;
    logic        hit;

    modport master (output address, load, in, input out, hit);
    modport slave  (input address, load, in, output out, hit);
endinterface

// File: rtl/mmio_seg_display_hex_to_seg.sv
// Combinational nibble-to-glyph decoder.
// The output is active-high; polarity is applied by the caller.
module hex_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Plain table lookup keeps the glyph set in one place (the package).
    always_comb begin
        seg = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/mmio_seg_display.sv
// Memory-mapped N-digit multiplexed 7-segment display.
// Features: shadow/active digit storage with optional frame-synchronous commit,
// per-digit blank and decimal-point masks, and anti-ghosting blanking at the
// start of each digit slot.
module mmio_seg_display
    import seg_display_pkg::*;
#(
    parameter int          NUM_DIGITS     = 4,
    parameter logic [15:0] BASE_ADDR      = 16'h4000,
    parameter int          REFRESH_DIV    = 50000,
    parameter int          BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_seg_display_if.slave     bus,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick
);

    localparam int NW    = num_words(NUM_DIGITS);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [15:0] CTRL_OFF   = 16'(NW + CTRL_REL);
    localparam logic [15:0] BLANK_OFF  = 16'(NW + BLANK_REL);
    localparam logic [15:0] STATUS_OFF = 16'(NW + STATUS_REL);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q;
    logic             div_last;
    logic             frame_end;

    // Register file
    logic [NUM_DIGITS*4-1:0] shadow_q;
    logic [NUM_DIGITS*4-1:0] active_q;
    logic [NW*16-1:0]        shadow_words;
    logic                    en_q;
    logic                    sync_q;
    logic [NUM_DIGITS-1:0]   dp_mask_q;
    logic [NUM_DIGITS-1:0]   blank_mask_q;
    logic                    pending_q;

    // Bus decode
    logic [15:0] offset;
    logic        in_window;
    logic        wr_data;
    logic        wr_ctrl;
    logic        wr_blank;
    logic [15:0] rd_data;

    // Current-slot values feeding the output registers
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] en_vec;

    assign offset    = bus.address - BASE_ADDR;
    assign in_window = (bus.address >= BASE_ADDR) && (offset <= STATUS_OFF);
    assign wr_data   = bus.load && in_window && (offset < 16'(NW));
    assign wr_ctrl   = bus.load && in_window && (offset == CTRL_OFF);
    assign wr_blank  = bus.load && in_window && (offset == BLANK_OFF);

    assign div_last   = (div_q == DIV_LAST);
    assign frame_end  = div_last && (idx_q == IDX_LAST);
    assign frame_tick = frame_end;

    assign shadow_words = (NW*16)'(shadow_q);
    assign bus.hit      = in_window;
    assign bus.out      = rd_data;

    // Divider and digit index: the scan free-runs regardless of EN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_last) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // CPU writes to shadow digits, CTRL and BLANK; mask bits past the last digit are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q     <= '0;
            en_q         <= 1'b1;
            sync_q       <= 1'b0;
            dp_mask_q    <= '0;
            blank_mask_q <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                for (int i = 0; i < 4; i++) begin
                    if ((4*k + i < NUM_DIGITS) && wr_data && (offset == 16'(k))) begin
                        shadow_q[(4*k + i)*4 +: 4] <= bus.in[i*4 +: 4];
                    end
                end
            end
            if (wr_ctrl) begin
                en_q      <= bus.in[CTRL_EN_BIT];
                sync_q    <= bus.in[CTRL_SYNC_BIT];
                dp_mask_q <= bus.in[CTRL_DP_LSB +: NUM_DIGITS];
            end
            if (wr_blank) begin
                blank_mask_q <= bus.in[NUM_DIGITS-1:0];
            end
        end
    end

    // Shadow-to-active commit: every cycle when unsynchronised, else only at the frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q  <= '0;
            pending_q <= 1'b0;
        end else if (!sync_q) begin
            active_q  <= shadow_q;
            pending_q <= 1'b0;
        end else begin
            if (frame_end && pending_q) begin
                active_q <= shadow_q;
            end
            if (wr_data) begin
                pending_q <= 1'b1;
            end else if (frame_end) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Read mux: zero outside the window and for unimplemented bits.
    always_comb begin
        rd_data = '0;
        if (in_window) begin
            for (int k = 0; k < NW; k++) begin
                if (offset == 16'(DATA_OFF + k)) begin
                    rd_data = shadow_words[k*16 +: 16];
                end
            end
            if (offset == CTRL_OFF) begin
                rd_data[CTRL_EN_BIT]                   = en_q;
                rd_data[CTRL_SYNC_BIT]                 = sync_q;
                rd_data[CTRL_DP_LSB +: NUM_DIGITS]     = dp_mask_q;
            end
            if (offset == BLANK_OFF) begin
                rd_data[NUM_DIGITS-1:0] = blank_mask_q;
            end
            if (offset == STATUS_OFF) begin
                rd_data[STATUS_PEND_BIT]           = pending_q;
                rd_data[STATUS_IDX_LSB +: IDX_W]   = idx_q;
            end
        end
    end

    // Select the current digit's nibble, DP bit and enable (after anti-ghost blanking).
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        en_vec     = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                cur_nibble = active_q[d*4 +: 4];
                cur_dp     = dp_mask_q[d];
                en_vec[d]  = en_q && (div_q >= BLANK_END) && !blank_mask_q[d];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Register the pad outputs with polarity applied last, so pins never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_out  <= {7{SEG_ACTIVE_LOW}};
            dp_out   <= SEG_ACTIVE_LOW;
            digit_en <= {NUM_DIGITS{EN_ACTIVE_LOW}};
        end else begin
            seg_out  <= cur_seg ^ {7{SEG_ACTIVE_LOW}};
            dp_out   <= cur_dp ^ SEG_ACTIVE_LOW;
            digit_en <= en_vec ^ {NUM_DIGITS{EN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_mmio_seg_display.sv
// Directed bench for mmio_seg_display.
// Configuration: 4 digits, REFRESH_DIV=4, BLANK_CYCLES=1, active-low segments
// and digit enables. Scan walks use vector tables; the synchronous-commit and
// reset corner cases use hand-written sequences.
module tb_mmio_seg_display;

    typedef struct {
        logic [3:0] en;
        logic       tick;
        logic [6:0] seg;
        logic       dp;
    } scan_vec_t;

    typedef struct {
        logic [15:0] addr;
        logic        hit;
        logic [15:0] data;
    } read_vec_t;

    logic       clk;
    logic       reset;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [3:0] digit_en;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    scan_vec_t scan_tbl [16];
    scan_vec_t mask_tbl [16];
    read_vec_t read_tbl [5];

    mmio_seg_display_if bus ();

    mmio_seg_display #(
        .NUM_DIGITS     (4),
        .BASE_ADDR      (16'h4000),
        .REFRESH_DIV    (4),
        .BLANK_CYCLES   (1),
        .SEG_ACTIVE_LOW (1'b1),
        .EN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // One-cycle bus write, issued at a falling edge.
    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data);
        bus.address = addr;
        bus.in      = data;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
        bus.address = 16'h0000;
        bus.in      = 16'h0000;
    endtask

    task automatic checkRead(input string name, input logic [15:0] addr, input logic exp_hit, input logic [15:0] exp_data);
        bus.address = addr;
        bus.load    = 1'b0;
        #1;
        checkOutput({name, "_hit"}, 16'(bus.hit), 16'(exp_hit));
        checkOutput({name, "_data"}, bus.out, exp_data);
        bus.address = 16'h0000;
    endtask

    task automatic waitTick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 64);
        if (!frame_tick) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_tick_timeout actual=0 expected=1");
        end
    endtask

    initial begin
        // After reset release: observation n=1..16 reflects the slot state of cycle n-1.
        scan_tbl[0]  = '{4'hF, 1'b0, 7'h40, 1'b1};
        scan_tbl[1]  = '{4'hE, 1'b0, 7'h40, 1'b1};
        scan_tbl[2]  = '{4'hE, 1'b0, 7'h40, 1'b1};
        scan_tbl[3]  = '{4'hE, 1'b0, 7'h40, 1'b1};
        scan_tbl[4]  = '{4'hF, 1'b0, 7'h40, 1'b1};
        scan_tbl[5]  = '{4'hD, 1'b0, 7'h40, 1'b1};
        scan_tbl[6]  = '{4'hD, 1'b0, 7'h40, 1'b1};
        scan_tbl[7]  = '{4'hD, 1'b0, 7'h40, 1'b1};
        scan_tbl[8]  = '{4'hF, 1'b0, 7'h40, 1'b1};
        scan_tbl[9]  = '{4'hB, 1'b0, 7'h40, 1'b1};
        scan_tbl[10] = '{4'hB, 1'b0, 7'h40, 1'b1};
        scan_tbl[11] = '{4'hB, 1'b0, 7'h40, 1'b1};
        scan_tbl[12] = '{4'hF, 1'b0, 7'h40, 1'b1};
        scan_tbl[13] = '{4'h7, 1'b0, 7'h40, 1'b1};
        scan_tbl[14] = '{4'h7, 1'b1, 7'h40, 1'b1};
        scan_tbl[15] = '{4'h7, 1'b0, 7'h40, 1'b1};

        // Frame after a tick, data 5678, BLANK=0002, DP on digit 0.
        mask_tbl[0]  = '{4'h7, 1'b0, 7'h12, 1'b1};
        mask_tbl[1]  = '{4'hF, 1'b0, 7'h00, 1'b0};
        mask_tbl[2]  = '{4'hE, 1'b0, 7'h00, 1'b0};
        mask_tbl[3]  = '{4'hE, 1'b0, 7'h00, 1'b0};
        mask_tbl[4]  = '{4'hE, 1'b0, 7'h00, 1'b0};
        mask_tbl[5]  = '{4'hF, 1'b0, 7'h78, 1'b1};
        mask_tbl[6]  = '{4'hF, 1'b0, 7'h78, 1'b1};
        mask_tbl[7]  = '{4'hF, 1'b0, 7'h78, 1'b1};
        mask_tbl[8]  = '{4'hF, 1'b0, 7'h78, 1'b1};
        mask_tbl[9]  = '{4'hF, 1'b0, 7'h02, 1'b1};
        mask_tbl[10] = '{4'hB, 1'b0, 7'h02, 1'b1};
        mask_tbl[11] = '{4'hB, 1'b0, 7'h02, 1'b1};
        mask_tbl[12] = '{4'hB, 1'b0, 7'h02, 1'b1};
        mask_tbl[13] = '{4'hF, 1'b0, 7'h12, 1'b1};
        mask_tbl[14] = '{4'h7, 1'b0, 7'h12, 1'b1};
        mask_tbl[15] = '{4'h7, 1'b1, 7'h12, 1'b1};

        read_tbl[0] = '{16'h3FFF, 1'b0, 16'h0000};
        read_tbl[1] = '{16'h4004, 1'b0, 16'h0000};
        read_tbl[2] = '{16'h4000, 1'b1, 16'h5678};
        read_tbl[3] = '{16'h4001, 1'b1, 16'h0F01};
        read_tbl[4] = '{16'h4002, 1'b1, 16'h0002};

        bus.address = 16'h0000;
        bus.load    = 1'b0;
        bus.in      = 16'h0000;
        reset       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_seg", 16'(seg_out), 16'h007F);
        checkOutput("rst_dp", 16'(dp_out), 16'h0001);
        checkOutput("rst_en", 16'(digit_en), 16'h000F);
        checkOutput("rst_tick", 16'(frame_tick), 16'h0000);
        checkRead("rst_ctrl", 16'h4001, 1'b1, 16'h0001);
        checkRead("rst_status", 16'h4003, 1'b1, 16'h0000);
        reset = 1'b1;

        // Free-running scan walk
        for (int n = 0; n < 16; n++) begin
            step();
            checkOutput($sformatf("scan%0d_en", n), 16'(digit_en), 16'(scan_tbl[n].en));
            checkOutput($sformatf("scan%0d_tick", n), 16'(frame_tick), 16'(scan_tbl[n].tick));
            checkOutput($sformatf("scan%0d_seg", n), 16'(seg_out), 16'(scan_tbl[n].seg));
            checkOutput($sformatf("scan%0d_dp", n), 16'(dp_out), 16'(scan_tbl[n].dp));
        end

        // Unsynchronised DATA write: active one edge later, seg_out the edge after
        waitTick();
        repeat (3) step();
        applyStimulus(16'h4000, 16'h1234);
        checkOutput("nosync_edge1", 16'(seg_out), 16'h0040);
        step();
        checkOutput("nosync_edge2", 16'(seg_out), 16'h0040);
        step();
        checkOutput("nosync_edge3", 16'(seg_out), 16'h0030);
        checkRead("data_rd", 16'h4000, 1'b1, 16'h1234);
        waitTick();
        repeat (3) step();
        checkOutput("digit0_en", 16'(digit_en), 16'h000E);
        checkOutput("digit0_seg", 16'(seg_out), 16'h0019);

        // Frame-synchronous update: held until the frame boundary
        applyStimulus(16'h4001, 16'h0003);
        waitTick();
        repeat (3) step();
        applyStimulus(16'h4000, 16'hABCD);
        checkRead("sync_pend", 16'h4003, 1'b1, 16'h0001);
        checkRead("sync_shadow", 16'h4000, 1'b1, 16'hABCD);
        waitTick();
        checkOutput("sync_old_seg", 16'(seg_out), 16'h0079);
        checkRead("sync_pend_tick", 16'h4003, 1'b1, 16'h0301);
        repeat (2) step();
        checkOutput("sync_new_seg", 16'(seg_out), 16'h0021);
        checkRead("sync_pend_clr", 16'h4003, 1'b1, 16'h0000);

        // DATA write coinciding with the frame boundary commits the old shadow
        waitTick();
        applyStimulus(16'h4000, 16'h5678);
        checkRead("coll_pend", 16'h4003, 1'b1, 16'h0001);
        step();
        checkOutput("coll_old_seg", 16'(seg_out), 16'h0021);
        waitTick();
        checkRead("coll_pend_tick", 16'h4003, 1'b1, 16'h0301);
        repeat (2) step();
        checkOutput("coll_new_seg", 16'(seg_out), 16'h0000);
        checkRead("coll_pend_clr", 16'h4003, 1'b1, 16'h0000);

        // Blank mask on digit 1, decimal point on digit 0
        applyStimulus(16'h4002, 16'h0002);
        applyStimulus(16'h4001, 16'h0101);
        waitTick();
        for (int j = 0; j < 16; j++) begin
            step();
            checkOutput($sformatf("mask%0d_en", j), 16'(digit_en), 16'(mask_tbl[j].en));
            checkOutput($sformatf("mask%0d_tick", j), 16'(frame_tick), 16'(mask_tbl[j].tick));
            checkOutput($sformatf("mask%0d_seg", j), 16'(seg_out), 16'(mask_tbl[j].seg));
            checkOutput($sformatf("mask%0d_dp", j), 16'(dp_out), 16'(mask_tbl[j].dp));
        end

        // Out-of-window, STATUS and out-of-range mask writes are ignored
        applyStimulus(16'h3FFF, 16'hFFFF);
        applyStimulus(16'h4004, 16'hFFFF);
        applyStimulus(16'h4003, 16'hFFFF);
        applyStimulus(16'h4001, 16'hFFFD);
        applyStimulus(16'h4002, 16'hFFF2);
        for (int r = 0; r < 5; r++) begin
            checkRead($sformatf("win%0d", r), read_tbl[r].addr, read_tbl[r].hit, read_tbl[r].data);
        end
        bus.address = 16'h4003;
        #1;
        checkOutput("status_unused", bus.out & 16'hF8FF, 16'h0000);
        bus.address = 16'h0000;

        // Clearing SYNC while a commit is pending commits on the next edge
        applyStimulus(16'h4001, 16'h0003);
        waitTick();
        step();
        applyStimulus(16'h4000, 16'h9999);
        checkRead("unsync_pend", 16'h4003, 1'b1, 16'h0001);
        applyStimulus(16'h4001, 16'h0001);
        step();
        checkRead("unsync_clr", 16'h4003, 1'b1, 16'h0000);
        step();
        checkOutput("unsync_seg", 16'(seg_out), 16'h0010);

        // Asynchronous reset mid-slot forces outputs off and drops pending data
        waitTick();
        repeat (2) step();
        applyStimulus(16'h4001, 16'h0103);
        applyStimulus(16'h4000, 16'h2222);
        checkOutput("pre_rst_en", 16'(digit_en), 16'h000E);
        checkOutput("pre_rst_dp", 16'(dp_out), 16'h0000);
        checkOutput("pre_rst_seg", 16'(seg_out), 16'h0010);
        checkRead("pre_rst_pend", 16'h4003, 1'b1, 16'h0001);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_seg", 16'(seg_out), 16'h007F);
        checkOutput("mid_rst_dp", 16'(dp_out), 16'h0001);
        checkOutput("mid_rst_en", 16'(digit_en), 16'h000F);
        checkOutput("mid_rst_tick", 16'(frame_tick), 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        checkRead("post_rst_status", 16'h4003, 1'b1, 16'h0000);
        checkRead("post_rst_data", 16'h4000, 1'b1, 16'h0000);
        checkRead("post_rst_ctrl", 16'h4001, 1'b1, 16'h0001);
        checkRead("post_rst_blank", 16'h4002, 1'b1, 16'h0000);
        step();
        checkOutput("post_rst_seg", 16'(seg_out), 16'h0040);
        checkOutput("post_rst_en", 16'(digit_en), 16'h000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
